// File: rtl/serie_paralelo_rx_lane.sv
// Receive-side lane deserializer: recovers byte alignment from a run of COM
// symbols, then emits each non-COM byte as a parallel word with a valid flag.
//
// Handshake: there is no backpressure. byte_strobe pulses for one cycle per
// byte slot in ACTIVE. valid_out qualifies data_out for that whole slot.
module serie_paralelo_rx_lane #(
   parameter logic [7:0]  COM         = 8'hBC,
   parameter int unsigned ACTIVE_COMS = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_ALIGN  = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] LP_NCOM = 4'(ACTIVE_COMS);

   state_t     r_state, w_state_nx;
   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt, w_bit_cnt_nx;
   logic [3:0] r_com_cnt, w_com_cnt_nx;
   logic [7:0] r_data, w_data_nx;
   logic       r_valid, w_valid_nx;
   logic       r_strobe, w_strobe_nx;
   logic       r_active, w_active_nx;
   logic [7:0] w_cand;
   logic       w_is_com;
   logic       w_slot;

   // The byte completed by the bit being sampled on this edge.
   assign w_cand   = {r_sr[6:0], data_in};
   assign w_is_com = (w_cand == COM);
   assign w_slot   = (r_bit_cnt == 3'd7);

   always_comb begin
      w_state_nx   = r_state;
      w_bit_cnt_nx = r_bit_cnt;
      w_com_cnt_nx = r_com_cnt;
      w_data_nx    = r_data;
      w_valid_nx   = r_valid;
      w_strobe_nx  = 1'b0;
      w_active_nx  = r_active;
      case (r_state)
         S_SEARCH: begin
            if (w_is_com) begin
               w_bit_cnt_nx = 3'd0;
               w_com_cnt_nx = 4'd1;
               if (LP_NCOM == 4'd1) begin
                  w_state_nx  = S_ACTIVE;
                  w_active_nx = 1'b1;
               end else begin
                  w_state_nx = S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (w_slot) begin
               if (w_is_com && (r_com_cnt + 4'd1 == LP_NCOM)) begin
                  w_state_nx   = S_ACTIVE;
                  w_active_nx  = 1'b1;
                  w_com_cnt_nx = LP_NCOM;
               end else if (w_is_com) begin
                  w_com_cnt_nx = r_com_cnt + 4'd1;
               end else begin
                  // The broken slot itself is not re-searched; sliding resumes next edge.
                  w_state_nx   = S_SEARCH;
                  w_com_cnt_nx = 4'd0;
               end
            end
         end
         S_ACTIVE: begin
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (w_slot) begin
               w_strobe_nx = 1'b1;
               if (w_is_com) begin
                  w_valid_nx = 1'b0;
               end else begin
                  w_data_nx  = w_cand;
                  w_valid_nx = 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = S_SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         r_state   <= S_SEARCH;
         r_sr      <= 8'd0;
         r_bit_cnt <= 3'd0;
         r_com_cnt <= 4'd0;
         r_data    <= 8'd0;
         r_valid   <= 1'b0;
         r_strobe  <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_sr      <= w_cand;
         r_bit_cnt <= w_bit_cnt_nx;
         r_com_cnt <= w_com_cnt_nx;
         r_data    <= w_data_nx;
         r_valid   <= w_valid_nx;
         r_strobe  <= w_strobe_nx;
         r_active  <= w_active_nx;
      end
   end

   assign data_out    = r_data;
   assign valid_out   = r_valid;
   assign byte_strobe = r_strobe;
   assign active      = r_active;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_serie_paralelo_rx_lane.sv
// Bench for serie_paralelo_rx_lane: two lanes (4-COM and 1-COM lock) share one
// serial input and are checked against directed constants and a stream model.
module tb_serie_paralelo_rx_lane;

  localparam logic [7:0] COM = 8'hBC;

  typedef struct packed {
    logic       act;
    logic       stb;
    logic       vld;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    logic [7:0] tx;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] d4, d1;
  logic       v4, v1, s4, s1, a4, a1;
  logic [1:0] st4, st1;

  int n_checks = 0;
  int n_err    = 0;
  bit hist[$];

  // clock / reset
  always #5 clk_8f = ~clk_8f;

  serie_paralelo_rx_lane #(.COM(COM), .ACTIVE_COMS(4)) u4 (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
    .data_out(d4), .valid_out(v4), .byte_strobe(s4), .active(a4), .dbg_state(st4)
  );

  serie_paralelo_rx_lane #(.COM(COM), .ACTIVE_COMS(1)) u1 (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
    .data_out(d1), .valid_out(v1), .byte_strobe(s1), .active(a1), .dbg_state(st1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stream level) ----------------
  // Byte ending at bit i (1-based), with zeros before the first bit.
  function automatic logic [7:0] win(input int i);
    logic [7:0] w;
    w = 8'd0;
    for (int k = i - 7; k <= i; k++)
      w = {w[6:0], (k >= 1) ? logic'(hist[k-1]) : 1'b0};
    return w;
  endfunction

  function automatic exp_t predict(input int n);
    exp_t e;
    int   len, i, j, cnt, lock_at;
    e = '0;
    len = hist.size();
    lock_at = -1;
    i = 1;
    while (lock_at < 0 && i <= len) begin
      if (win(i) == COM) begin
        cnt = 1;
        j = i;
        while (cnt < n) begin
          j += 8;
          if (j > len) break;
          if (win(j) == COM) cnt++;
          else break;
        end
        if (cnt >= n) lock_at = j;
        else i = j + 1;
      end else begin
        i++;
      end
    end
    if (lock_at >= 0) begin
      e.act = 1'b1;
      for (int k = lock_at + 8; k <= len; k += 8) begin
        if (win(k) == COM) e.vld = 1'b0;
        else begin
          e.vld = 1'b1;
          e.dat = win(k);
        end
      end
      e.stb = (len > lock_at) && (((len - lock_at) % 8) == 0);
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit mchk);
    data_in = b;
    hist.push_back(b);
    @(posedge clk_8f);
    #1;
    if (mchk) begin
      chk("model_lane4", {5'd0, a4, s4, v4, d4}, {5'd0, predict(4)});
      chk("model_lane1", {5'd0, a1, s1, v1, d1}, {5'd0, predict(1)});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit mchk);
    for (int i = 7; i >= 0; i--) send_bit(b[i], mchk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_8f);
      #1;
      chk("reset_lane4", {5'd0, a4, s4, v4, d4}, 16'd0);
      chk("reset_lane1", {5'd0, a1, s1, v1, d1}, 16'd0);
    end
    reset = 1'b0;
    hist.delete();
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] b;
    logic [7:0] com_v;
    logic [7:0] slip;
    com_v = COM;
    slip  = 8'b1010_0000;

    vecs[0] = '{8'h55, 1'b1, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 8'hA3};
    vecs[2] = '{8'hBC, 1'b0, 8'hA3};
    vecs[3] = '{8'h00, 1'b1, 8'h00};
    vecs[4] = '{8'hBC, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF};

    // reset values
    do_reset(3);

    // clean lock: active rises exactly on bit 32, locking COM gives no strobe
    for (int k = 1; k <= 32; k++) begin
      send_bit(com_v[(32 - k) % 8], 1'b0);
      chk("lock_active", {15'd0, a4}, {15'd0, logic'(k == 32)});
    end
    chk("lock_no_strobe", {14'd0, s4, v4}, 16'd0);
    foreach (vecs[n]) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(vecs[n].tx[i], 1'b0);
        if (i != 0) chk("vec_strobe_low", {15'd0, s4}, 16'd0);
      end
      chk("vec_strobe", {15'd0, s4}, 16'd1);
      chk("vec_valid", {15'd0, v4}, {15'd0, vecs[n].exp_valid});
      chk("vec_data", {8'd0, d4}, {8'd0, vecs[n].exp_data});
    end

    // bit-slip: three stray bits before the COM run
    do_reset(1);
    for (int i = 7; i >= 5; i--) send_bit(slip[i], 1'b0);
    repeat (4) send_byte(COM, 1'b0);
    chk("slip_active", {15'd0, a4}, 16'd1);
    send_byte(8'h3C, 1'b0);
    chk("slip_out", {13'd0, s4, v4, 1'b0} | {8'd0, d4}, {13'd0, 3'b110} | 16'h3C);
    chk("slip_data", {8'd0, d4}, 16'h3C);

    // broken COM run, then a full run
    do_reset(1);
    repeat (3) send_byte(COM, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("broken_no_active", {15'd0, a4}, 16'd0);
    repeat (3) send_byte(COM, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(com_v[i], 1'b0);
    chk("broken_not_yet", {15'd0, a4}, 16'd0);
    send_bit(com_v[0], 1'b0);
    chk("broken_active", {15'd0, a4}, 16'd1);
    send_byte(8'h11, 1'b0);
    chk("broken_data", {6'd0, s4, v4, d4}, {6'd0, 2'b11, 8'h11});

    // reset mid-byte in ACTIVE (lane is active from the previous test)
    b = 8'h77;
    for (int i = 7; i >= 5; i--) send_bit(b[i], 1'b0);
    do_reset(1);
    for (int i = 4; i >= 0; i--) begin
      send_bit(b[i], 1'b0);
      chk("midrst_quiet", {5'd0, a4, s4, v4, d4}, 16'd0);
    end
    repeat (4) send_byte(COM, 1'b0);
    chk("midrst_relock", {15'd0, a4}, 16'd1);
    send_byte(8'h22, 1'b0);
    chk("midrst_data", {6'd0, s4, v4, d4}, {6'd0, 2'b11, 8'h22});

    // single-COM lock on lane 1
    do_reset(1);
    for (int i = 7; i >= 1; i--) send_bit(com_v[i], 1'b0);
    chk("one_com_pre", {15'd0, a1}, 16'd0);
    send_bit(com_v[0], 1'b0);
    chk("one_com_active", {14'd0, a1, s1}, 16'b10);
    send_byte(8'h9A, 1'b0);
    chk("one_com_data", {6'd0, s1, v1, d1}, {6'd0, 2'b11, 8'h9A});

    // randomized streams checked every cycle against the model
    for (int r = 0; r < 24; r++) begin
      do_reset($urandom_range(1, 3));
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 6)) begin
        b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : COM;
        send_byte(b, 1'b1);
      end
      repeat ($urandom_range(4, 12)) begin
        b = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
        send_byte(b, 1'b1);
      end
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
